// File: rtl/apb_rst_seq.sv
// ---------------------------------------------------------------------------
// apb_rst_seq
//   Fans the PMU system reset request out to NUM_RST reset domains. All
//   domains enter reset together; release is staged one domain at a time,
//   with an APB-programmable delay in front of each stage.
//
// Ports
//   pclk, presetn        APB clock, asynchronous active-low reset
//   psel/penable/pwrite  APB control
//   paddr, pwdata        APB address (only [7:0] decoded) and write data
//   prdata               registered APB read data
//   sys_rst_n            reset request from PMU (low = hold reset)
//   rst_n_o              sequenced active-low domain resets
//   seq_busy             high while the release sequence is running
//
// Register map
//   0x00  STATUS  RO  [0]=seq_busy [2:1]=state [6:4]=idx [8+:NUM_RST]=rst_n_o
//   0x04+4*i DLY_i RW [CNT_WIDTH-1:0] stage delay, reset 8'h10
//   0x40  SEQ_CNT RO  completed-sequence count (only with RST_SEQ_CNT_EN,
//                     otherwise reads 0)
// ---------------------------------------------------------------------------
module apb_rst_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RST    = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  penable,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  sys_rst_n,
    output logic [NUM_RST-1:0]    rst_n_o,
    output logic                  seq_busy
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        REL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [2:0]             idx, idx_nx, idx_inc;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nx, dly_nxt;
    logic [NUM_RST-1:0]     rst_nx;
    logic                   busy_nx;
    logic [CNT_WIDTH-1:0]   dly [NUM_RST];

    logic                   wr_en, rd_en;
    logic [7:0]             addr;
    logic [5:0]             word, dly_sel;
    logic                   dly_hit;
    logic [DATA_WIDTH-1:0]  rd_val;

    logic unused_bits;
    assign unused_bits = ^{paddr[ADDR_WIDTH-1:8], pwdata[DATA_WIDTH-1:CNT_WIDTH]};

    assign wr_en   = psel & penable & pwrite;
    assign rd_en   = psel & ~penable & ~pwrite;
    assign addr    = paddr[7:0];
    assign word    = addr[7:2];
    assign dly_sel = word - 6'd1;
    assign dly_hit = (addr[1:0] == 2'b00) && (word != 6'd0) && (word <= 6'(NUM_RST));
    assign idx_inc = idx + 3'd1;

    // Delay of the stage that follows the current one.
    always_comb begin
        dly_nxt = '0;
        for (int unsigned i = 0; i < NUM_RST; i++) begin
            if (idx_inc == 3'(i)) dly_nxt = dly[i];
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        rst_nx   = rst_n_o;
        case (state)
            HOLD: begin
                rst_nx = '0;
                if (sys_rst_n) begin
                    state_nx = REL;
                    idx_nx   = '0;
                    cnt_nx   = dly[0];
                end
            end
            REL: begin
                if (!sys_rst_n) begin
                    state_nx = HOLD;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    rst_nx   = '0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    rst_nx = rst_n_o | (NUM_RST'(1) << idx);
                    if (idx == 3'(NUM_RST - 1)) begin
                        // idx returns to 0 in DONE so STATUS reads 0x..04 there.
                        state_nx = DONE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx_inc;
                        cnt_nx = dly_nxt;
                    end
                end
            end
            DONE: begin
                rst_nx = '1;
                if (!sys_rst_n) begin
                    state_nx = HOLD;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    rst_nx   = '0;
                end
            end
            default: begin
                state_nx = HOLD;
                idx_nx   = '0;
                cnt_nx   = '0;
                rst_nx   = '0;
            end
        endcase
        busy_nx = (state_nx == REL);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= HOLD;
            idx      <= '0;
            cnt      <= '0;
            rst_n_o  <= '0;
            seq_busy <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            cnt      <= cnt_nx;
            rst_n_o  <= rst_nx;
            seq_busy <= busy_nx;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_RST; i++) dly[i] <= CNT_WIDTH'(16);
        end else if (wr_en && dly_hit) begin
            for (int unsigned i = 0; i < NUM_RST; i++) begin
                if (dly_sel == 6'(i)) dly[i] <= pwdata[CNT_WIDTH-1:0];
            end
        end
    end

`ifdef RST_SEQ_CNT_EN
    logic [15:0] seq_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            seq_cnt <= '0;
        end else if (state == REL && state_nx == DONE && seq_cnt != 16'hFFFF) begin
            seq_cnt <= seq_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        if (addr == 8'h00) begin
            rd_val[0]            = seq_busy;
            rd_val[2:1]          = state;
            rd_val[6:4]          = idx;
            rd_val[8 +: NUM_RST] = rst_n_o;
        end
        for (int unsigned i = 0; i < NUM_RST; i++) begin
            if (dly_hit && dly_sel == 6'(i)) rd_val[CNT_WIDTH-1:0] = dly[i];
        end
`ifdef RST_SEQ_CNT_EN
        if (addr == 8'h40) rd_val[15:0] = seq_cnt;
`endif
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prdata <= '0;
        end else if (rd_en) begin
            prdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_apb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_apb_rst_seq
//   Self-checking bench for apb_rst_seq (default parameters, NUM_RST=4).
//   Register table, hand-written timing sequences and randomized traffic,
//   all checked against a release-schedule reference model.
//   Honours RST_SEQ_CNT_EN for the SEQ_CNT expectation.
// ---------------------------------------------------------------------------
module tb_apb_rst_seq;

    localparam int NR = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, pwrite, penable, sys_rst_n;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic [NR-1:0] rst_n_o;
    logic        seq_busy;

    apb_rst_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_RST(NR), .CNT_WIDTH(8)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .penable(penable), .prdata(prdata),
        .sys_rst_n(sys_rst_n), .rst_n_o(rst_n_o), .seq_busy(seq_busy)
    );

    always #5 pclk = ~pclk;

    int nchk = 0;
    int nfail = 0;
    int ecnt = 0;

    // Reference model: phase 0=hold 1=releasing 2=all released,
    // mr = domains already released, mw = edges left until the next release.
    int        mphase, mr, mw, mseq;
    logic [7:0] mdly [NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mphase = 0; mr = 0; mw = 0; mseq = 0;
        for (int i = 0; i < NR; i++) mdly[i] = 8'h10;
    endfunction

    function automatic logic [NR-1:0] m_rst();
        if (mphase == 2) return '1;
        if (mphase == 1) return NR'((1 << mr) - 1);
        return '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] v = '0;
        if (a == 8'h00) begin
            v[0]        = (mphase == 1);
            v[2:1]      = 2'(mphase);
            v[6:4]      = (mphase == 1) ? 3'(mr) : 3'd0;
            v[8 +: NR]  = m_rst();
        end else if (a[1:0] == 2'b00 && a >= 8'h04 && a <= 8'(4 * NR)) begin
            v[7:0] = mdly[(a >> 2) - 1];
        end else if (a == 8'h40) begin
`ifdef RST_SEQ_CNT_EN
            v = 32'(mseq);
`else
            v = 32'h0;
`endif
        end
        return v;
    endfunction

    function automatic void model_step(input logic sys, input logic wr,
                                       input logic [7:0] a, input logic [31:0] d);
        case (mphase)
            0: if (sys) begin mphase = 1; mr = 0; mw = int'(mdly[0]) + 1; end
            1: if (!sys) begin mphase = 0; mr = 0; end
               else begin
                   mw--;
                   if (mw == 0) begin
                       mr++;
                       if (mr == NR) begin
                           mphase = 2;
                           if (mseq < 65535) mseq++;
                       end else mw = int'(mdly[mr]) + 1;
                   end
               end
            default: if (!sys) begin mphase = 0; mr = 0; end
        endcase
        // Register writes land after the stage loads of the same edge.
        if (wr && a[1:0] == 2'b00 && a >= 8'h04 && a <= 8'(4 * NR))
            mdly[(a >> 2) - 1] = d[7:0];
    endfunction

    // One clock edge: model follows the DUT, then outputs are compared.
    task automatic cycle();
        logic [31:0] exp_rd;
        logic did_rd;
        did_rd = psel && !penable && !pwrite;
        exp_rd = model_read(paddr[7:0]);
        @(posedge pclk);
        ecnt++;
        model_step(sys_rst_n, psel && penable && pwrite, paddr[7:0], pwdata);
        #1;
        chk("rst_n_o", 32'(rst_n_o), 32'(m_rst()));
        chk("seq_busy", 32'(seq_busy), 32'(mphase == 1));
        if (did_rd) chk("prdata", prdata, exp_rd);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1; pwrite = 1; penable = 0; paddr = 32'(a); pwdata = d;
        cycle();
        penable = 1;
        cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1; pwrite = 0; penable = 0; paddr = 32'(a);
        cycle();
        d = prdata;
        penable = 1;
        cycle();
        psel = 0; penable = 0;
    endtask

    task automatic do_reset();
        presetn = 0;
        sys_rst_n = 0;
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1;
        model_reset();
    endtask

    task automatic wait_rise(input int k, input int limit, output int e);
        int n = 0;
        while (rst_n_o[k] !== 1'b1 && n < limit) begin
            cycle();
            n++;
        end
        chk($sformatf("rise%0d_timeout", k), 32'(rst_n_o[k]), 32'h1);
        e = ecnt;
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    initial begin
        vec_t vt[12];
        logic [31:0] d;
        int t, e0, e1, e2, e3;

        vt[0]  = '{0, 8'h00, 32'h0,        32'h0,  "status_rst"};
        vt[1]  = '{0, 8'h04, 32'h0,        32'h10, "dly0_rst"};
        vt[2]  = '{0, 8'h10, 32'h0,        32'h10, "dly3_rst"};
        vt[3]  = '{1, 8'h08, 32'hFFFF_FFFF, 32'h0, ""};
        vt[4]  = '{0, 8'h08, 32'h0,        32'hFF, "dly1_upper0"};
        vt[5]  = '{1, 8'h14, 32'h55,       32'h0,  ""};
        vt[6]  = '{0, 8'h14, 32'h0,        32'h0,  "unmapped14"};
        vt[7]  = '{1, 8'h00, 32'hFFFF,     32'h0,  ""};
        vt[8]  = '{0, 8'h00, 32'h0,        32'h0,  "status_ro"};
        vt[9]  = '{0, 8'h40, 32'h0,        32'h0,  "seqcnt_rst"};
        vt[10] = '{1, 8'h08, 32'h10,       32'h0,  ""};
        vt[11] = '{0, 8'h0C, 32'h0,        32'h10, "dly2_rst"};

        psel = 0; pwrite = 0; penable = 0; paddr = '0; pwdata = '0;
        do_reset();

        // reset values, before any edge
        chk("rst_rst_n_o", 32'(rst_n_o), 32'h0);
        chk("rst_busy", 32'(seq_busy), 32'h0);
        chk("rst_prdata", prdata, 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) apb_write(vt[i].addr, vt[i].data);
            else begin
                apb_read(vt[i].addr, d);
                chk(vt[i].name, d, vt[i].exp);
            end
        end

        // default sequence: 17-cycle stage spacing
        sys_rst_n = 1; t = ecnt + 1;
        wait_rise(0, 100, e0); wait_rise(1, 100, e1);
        wait_rise(2, 100, e2); wait_rise(3, 100, e3);
        chk("def_s0", 32'(e0 - t), 32'd17);
        chk("def_s1", 32'(e1 - t), 32'd34);
        chk("def_s2", 32'(e2 - t), 32'd51);
        chk("def_s3", 32'(e3 - t), 32'd68);
        apb_read(8'h00, d);
        chk("def_status", d, 32'h0000_0F04);

        // programmed delays 0,3,0,255
        sys_rst_n = 0; cycle(); cycle();
        apb_write(8'h04, 0); apb_write(8'h08, 3);
        apb_write(8'h0C, 0); apb_write(8'h10, 255);
        sys_rst_n = 1; t = ecnt + 1;
        wait_rise(0, 300, e0); wait_rise(1, 300, e1);
        wait_rise(2, 300, e2); wait_rise(3, 300, e3);
        chk("prg_sp0", 32'(e0 - t), 32'd1);
        chk("prg_sp1", 32'(e1 - e0), 32'd4);
        chk("prg_sp2", 32'(e2 - e1), 32'd1);
        chk("prg_sp3", 32'(e3 - e2), 32'd256);

        // asynchronous reset in the middle of a sequence restores DLY
        sys_rst_n = 0; cycle();
        sys_rst_n = 1;
        wait_rise(2, 50, e2);
        repeat (10) cycle();
        presetn = 0; sys_rst_n = 0;
        #2;
        chk("async_rst_n_o", 32'(rst_n_o), 32'h0);
        chk("async_busy", 32'(seq_busy), 32'h0);
        #1 presetn = 1;
        model_reset();
        apb_read(8'h10, d);
        chk("async_dly3", d, 32'h10);

        // abort while rst_n_o = 0011, then restart from stage 0
        sys_rst_n = 1;
        wait_rise(1, 100, e1);
        chk("abort_pre", 32'(rst_n_o), 32'h3);
        sys_rst_n = 0; cycle();
        chk("abort_rst", 32'(rst_n_o), 32'h0);
        apb_read(8'h00, d);
        chk("abort_status", d, 32'h0);
        sys_rst_n = 1; t = ecnt + 1;
        wait_rise(0, 100, e0);
        chk("abort_restart", 32'(e0 - t), 32'd17);

        // live reprogramming during stage 0
        sys_rst_n = 0; cycle(); cycle();
        sys_rst_n = 1; t = ecnt + 1;
        cycle();
        apb_write(8'h0C, 5);
        apb_write(8'h04, 1);
        wait_rise(0, 100, e0); wait_rise(1, 100, e1); wait_rise(2, 100, e2);
        chk("live_s0", 32'(e0 - t), 32'd17);
        chk("live_sp2", 32'(e2 - e1), 32'd6);

        // completed-sequence counter
        do_reset();
        for (int i = 0; i < NR; i++) apb_write(8'(4 + 4 * i), 0);
        for (int s = 0; s < 3; s++) begin
            sys_rst_n = 1;
            wait_rise(3, 50, e3);
            cycle();
            sys_rst_n = 0; cycle(); cycle();
        end
        sys_rst_n = 1; cycle(); cycle();
        sys_rst_n = 0; cycle(); cycle();
        apb_read(8'h40, d);
`ifdef RST_SEQ_CNT_EN
        chk("seq_cnt", d, 32'd3);
`else
        chk("seq_cnt", d, 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < NR; i++) apb_write(8'(4 + 4 * i), 32'($urandom_range(0, 5)));
        for (int it = 0; it < 800; it++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                sys_rst_n = ($urandom_range(0, 3) != 0);
                cycle();
            end else if (r <= 2) begin
                apb_write(8'(4 * $urandom_range(1, NR + 1)), 32'($urandom_range(0, 5)));
            end else if (r <= 4) begin
                case ($urandom_range(0, 3))
                    0: apb_read(8'h00, d);
                    1: apb_read(8'h40, d);
                    2: apb_read(8'h14, d);
                    default: apb_read(8'(4 * $urandom_range(1, NR)), d);
                endcase
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #3_000_000;
        nfail++;
        $display("FAIL global_timeout act=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $fatal(1, "timeout");
    end

endmodule
